// File: rtl/deser_queue_pkg.sv
// Shared types and width helpers for the serial-to-word queue.
package deser_queue_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width must be able to represent the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/deser_queue_tick.sv
// Free-running divider that emits a one-clock enable every DIV clocks.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clock1M,
    input  logic reset,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_q == W'(DIV - 1)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign tick = (cnt_q == W'(DIV - 1));

endmodule

// File: rtl/deser_queue.sv
// Serial bit sampler feeding a DEPTH-entry word FIFO, drained on a slower tick.
module deser_queue
    import deser_queue_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int DES_DIV   = 10,
    parameter int DEQ_DIV   = 100,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clock1M,
    input  logic                          reset,
    input  logic                          data_in,
    input  logic                          write_in,
    input  logic                          dequeue_in,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    output logic [cnt_width(DEPTH)-1:0]   len_out,
    output logic                          status_out,
    output logic                          full,
    output logic                          overrun_out
);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int BC_W  = $clog2(DATA_W);

    logic des_tick, deq_tick;

    tick_gen #(.DIV(DES_DIV)) u_des_tick (.clock1M(clock1M), .reset(reset), .tick(des_tick));
    tick_gen #(.DIV(DEQ_DIV)) u_deq_tick (.clock1M(clock1M), .reset(reset), .tick(deq_tick));

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                data_valid_q, overrun_q;
    logic                push, pop, overrun_set;

    logic [DATA_W-1:0]   mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        push        = 1'b0;
        overrun_set = 1'b0;
        case (state_q)
            COLLECT: begin
                if (des_tick && write_in) begin
                    shift_d = MSB_FIRST ? {shift_q[DATA_W-2:0], data_in}
                                        : {data_in, shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        word_d    = shift_d;
                        bit_cnt_d = '0;
                        state_d   = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            HOLD: begin
                overrun_set = des_tick && write_in;
                // Push decision uses start-of-cycle occupancy, so a same-cycle pop cannot unblock it.
                if (count_q < CNT_W'(DEPTH)) begin
                    push    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign pop = deq_tick && dequeue_in && (count_q != '0);

    always_ff @(posedge clock1M) begin
        if (!reset) begin
            state_q      <= COLLECT;
            shift_q      <= '0;
            word_q       <= '0;
            bit_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            bit_cnt_q    <= bit_cnt_d;
            data_valid_q <= pop;
            if (overrun_set) overrun_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                data_out_q <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clock1M) begin
        if (push) mem[wr_ptr_q] <= word_q;
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign len_out     = count_q;
    assign status_out  = (state_q == COLLECT);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign overrun_out = overrun_q;

endmodule

// File: tb/tb_deser_queue.sv
// Directed bench: MSB/LSB-first assembly, full/overrun, pointer wrap and mid-word reset.
module tb_deser_queue;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int DES_DIV = 3;
    localparam int DEQ_DIV = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic data_in = 1'b0;
    logic wr_a = 1'b0, deq_a = 1'b0, wr_b = 1'b0, deq_b = 1'b0;

    logic [DATA_W-1:0] dout_a, dout_b;
    logic              dv_a, dv_b, st_a, st_b, full_a, full_b, ovr_a, ovr_b;
    logic [3:0]        len_a, len_b;

    int checks = 0;
    int errors = 0;
    int pulses_a = 0;

    always #5 clk = ~clk;

    deser_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .DEQ_DIV(DEQ_DIV), .MSB_FIRST(1'b1)) dut_a (
        .clock1M(clk), .reset(reset), .data_in(data_in), .write_in(wr_a), .dequeue_in(deq_a),
        .data_out(dout_a), .data_valid(dv_a), .len_out(len_a), .status_out(st_a),
        .full(full_a), .overrun_out(ovr_a));

    deser_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DES_DIV(DES_DIV), .DEQ_DIV(DEQ_DIV), .MSB_FIRST(1'b0)) dut_b (
        .clock1M(clk), .reset(reset), .data_in(data_in), .write_in(wr_b), .dequeue_in(deq_b),
        .data_out(dout_b), .data_valid(dv_b), .len_out(len_b), .status_out(st_b),
        .full(full_b), .overrun_out(ovr_b));

    // Counts clocks for which data_valid is high, i.e. dequeue pulses.
    always @(posedge clk) if (dv_a) pulses_a <= pulses_a + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // All stimulus tasks start and end on a falling edge; holding an input for
    // exactly DIV clocks guarantees it overlaps exactly one tick.
    task automatic send_bit(input logic b, input bit to_b);
        data_in = b;
        if (to_b) wr_b = 1'b1; else wr_a = 1'b1;
        repeat (DES_DIV) @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit to_b);
        for (int i = 7; i >= 0; i--) send_bit(w[i], to_b);
        @(negedge clk);
    endtask

    task automatic do_deq(input bit to_b);
        if (to_b) deq_b = 1'b1; else deq_a = 1'b1;
        repeat (DEQ_DIV) @(negedge clk);
        deq_a = 1'b0;
        deq_b = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] pat_b2;
    logic [7:0] exp_w;
    int p0;

    initial begin
        pat_b2 = 8'hB2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", dout_a, 8'h00);
        check("rst_len", len_a, 4'd0);
        check("rst_status", st_a, 1'b1);
        check("rst_full", full_a, 1'b0);
        check("rst_overrun", ovr_a, 1'b0);
        check("rst_valid", dv_a, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        send_word(pat_b2, 1'b0);
        check("msb_len_after_word", len_a, 4'd1);
        check("msb_status", st_a, 1'b1);
        p0 = pulses_a;
        do_deq(1'b0);
        check("msb_data_out", dout_a, 8'hB2);
        check("msb_valid_pulses", pulses_a - p0, 1);
        check("msb_len_after_deq", len_a, 4'd0);

        send_word(pat_b2, 1'b1);
        check("lsb_len_after_word", len_b, 4'd1);
        do_deq(1'b1);
        check("lsb_data_out", dout_b, 8'h4D);
        check("lsb_len_after_deq", len_b, 4'd0);

        for (int w = 1; w <= 8; w++) send_word(8'(w), 1'b0);
        check("fill_len", len_a, 4'd8);
        check("fill_full", full_a, 1'b1);
        send_word(8'hFF, 1'b0);
        check("hold_status", st_a, 1'b0);
        check("hold_len", len_a, 4'd8);
        check("pre_overrun", ovr_a, 1'b0);
        send_bit(1'b1, 1'b0);
        check("overrun_set", ovr_a, 1'b1);
        do_deq(1'b0);
        check("full_pop_data", dout_a, 8'h01);
        check("refill_len", len_a, 4'd8);
        check("refill_status", st_a, 1'b1);
        for (int k = 2; k <= 9; k++) begin
            exp_w = (k == 9) ? 8'hFF : 8'(k);
            do_deq(1'b0);
            check($sformatf("drain_%0d", k), dout_a, exp_w);
        end
        check("drain_len", len_a, 4'd0);
        check("drain_full", full_a, 1'b0);

        for (int i = 0; i < 12; i++) begin
            send_word(8'(8'h10 + i), 1'b0);
            do_deq(1'b0);
            check($sformatf("wrap_%0d", i), dout_a, 8'(8'h10 + i));
        end
        p0 = pulses_a;
        do_deq(1'b0);
        check("empty_pulses", pulses_a - p0, 0);
        check("empty_data_hold", dout_a, 8'h1B);
        check("empty_valid", dv_a, 1'b0);

        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_overrun", ovr_a, 1'b0);
        check("midrst_data_out", dout_a, 8'h00);
        check("midrst_len", len_a, 4'd0);
        send_word(8'hF0, 1'b0);
        do_deq(1'b0);
        check("midrst_word", dout_a, 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deser_queue.md
Name: deser_queue

Overview:
- Single-clock, parametrised successor of the deserializer + queue pair.
- Samples a serial bit stream on an internal bit-rate tick, assembles DATA_W-bit words and pushes them into a DEPTH-entry FIFO; words are dequeued on a slower internal tick.
- Replaces derived clocks with clock-enable ticks, adds selectable bit order, full/overrun flags and a data_valid strobe.
- Sits between the serial input pins and the word consumer at top level.

Parameters:
- DATA_W, 8, word width in bits (>=2)
- DEPTH, 8, FIFO entries (power of two, >=2)
- DES_DIV, 10, clocks per bit-sample tick (>=1; 10 = 100 kHz from 1 MHz)
- DEQ_DIV, 100, clocks per dequeue tick (>=1; 100 = 10 kHz from 1 MHz)
- MSB_FIRST, 1, 1: first received bit lands in the word MSB; 0: first bit lands in the LSB

Ports:
- clock1M  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clock1M rising edge)
- data_in  in  1  serial data bit
- write_in  in  1  bit-valid qualifier, sampled on the bit tick
- dequeue_in  in  1  dequeue request, sampled on the dequeue tick
- data_out  out  DATA_W  last dequeued word (registered, held)
- data_valid  out  1  one-clock pulse when data_out is updated
- len_out  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH
- status_out  out  1  1 = deserializer accepting bits (COLLECT); 0 = word held (HOLD)
- full  out  1  len_out == DEPTH
- overrun_out  out  1  sticky: a bit was offered while in HOLD

Behaviour:
- Reset (reset==0 at an edge): tick counters, bit_cnt, pointers and count cleared; state=COLLECT. Outputs: data_out=0, data_valid=0, len_out=0, status_out=1, full=0, overrun_out=0. Reset overrides all other activity, including mid-word.
- Ticks: des_cnt counts 0..DES_DIV-1 and wraps; des_tick=1 for the single clock where des_cnt==DES_DIV-1. deq_tick is derived identically from DEQ_DIV. Both counters free-run from reset.
- FSM COLLECT:
  - On des_tick & write_in: shift data_in into the shift register and increment bit_cnt.
  - MSB_FIRST=1: shift left, new bit enters the LSB. MSB_FIRST=0: shift right, new bit enters the MSB.
  - When the shifted bit is bit DATA_W-1: latch the word, clear bit_cnt, go to HOLD.
  - If write_in==0 on a tick: nothing is sampled; the partial word is retained.
- FSM HOLD:
  - status_out=0.
  - If count<DEPTH at the start of the cycle: push the word (mem[wr_ptr]<=word, wr_ptr++, count++) and return to COLLECT.
  - Otherwise stay in HOLD.
  - des_tick & write_in while in HOLD: the bit is dropped and overrun_out<=1 (cleared only by reset).
- Latency: last bit sampled at edge t; word is in the FIFO and len_out is incremented at edge t+1 if the FIFO is not full.
- Dequeue: on deq_tick & dequeue_in & count>0:
  - data_out<=mem[rd_ptr], rd_ptr++, count--, data_valid<=1 for one clock.
  - Otherwise data_valid<=0 and data_out holds.
- Simultaneous push and pop:
  - Both use start-of-cycle count; net count change is 0.
  - Push is blocked when count==DEPTH even if a pop occurs in the same cycle; it succeeds on the next clock.
  - Pop on an empty FIFO is ignored even if a push occurs in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full is combinational from count.

Decomposition:
- Package deser_queue_pkg:
  - state enum {COLLECT, HOLD}
  - localparam helper for pointer and count widths
- Sub-module tick_gen (param DIV; ports clock1M, reset, tick), instantiated twice.
- FIFO storage stays inline.

Test Plan:
- Reset: hold reset=0 for 3 clocks -> data_out=0, len_out=0, status_out=1, full=0, overrun_out=0, data_valid=0.
- MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on 8 des_ticks -> len_out=1 one clock after the 8th tick. Dequeue -> data_out=8'hB2, data_valid pulses once, len_out=0.
- MSB_FIRST=0, same bits -> dequeued data_out=8'h4D.
- Full and overrun:
  - Enqueue 8'h01..8'h08 -> full=1, len_out=8.
  - 9th word 8'hFF completes -> status_out=0.
  - One more bit offered -> overrun_out=1.
  - Dequeue -> data_out=8'h01; next clock 8'hFF is pushed, len_out=8, status_out=1.
- Wrap and empty: stream 12 words 8'h10..8'h1B with interleaved dequeues -> output order identical. Dequeue on empty -> data_valid=0, data_out unchanged.
- Reset mid-word: 5 bits sent, then reset=0 for one clock -> next 8 bits 1,1,1,1,0,0,0,0 yield 8'hF0 (no stale bits).
